cla_word_sequencer: RTL and testbench
=====================================

Name: cla_word_sequencer

Overview:
- Multi-precision add/subtract controller that reuses one external 16-bit carry-lookahead adder over NUM_WORDS cycles, 16 bits per cycle, least-significant word first.
- Latches full-width operands on start, drives the shared adder's a/b/c_in each cycle and captures its sum/c_out.
- Registers the final result with carry, overflow and a done pulse.
- Sits between the ALU control path and the 16-bit CLA datapath.

Parameters:
- NUM_WORDS, 4, number of 16-bit words per operand; operand width W = 16*NUM_WORDS; legal range 2..8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new operation; sampled only when not busy.
- sub  input  1  0 = A+B, 1 = A-B; sampled with start.
- op_a  input  W  operand A; sampled with start.
- op_b  input  W  operand B; sampled with start.
- add_a  output  16  word to shared adder a.
- add_b  output  16  word to shared adder b (already inverted when sub).
- add_cin  output  1  carry into shared adder.
- add_sum  input  16  shared adder sum (combinational from add_a/add_b/add_cin).
- add_cout  input  1  shared adder c_out.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result valid.
- result  output  W  registered sum/difference; held until next done.
- c_out  output  1  final carry out (sub: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset, asynchronous and active-low: state=IDLE, word index=0, busy=0, done=0, result=0, c_out=0, ovf=0, add_a=0, add_b=0, add_cin=0, internal operand and carry registers=0.
- FSM states:
  - IDLE: busy=0. start=1 latches op_a, op_b^{W{sub}} and carry=sub, clears index, goes to RUN.
  - RUN: busy=1. Drives add_a=A[16k+:16], add_b=B'[16k+:16] and add_cin=carry from registers. At each edge, stores add_sum into result word k, carry<=add_cout and k<=k+1. After word NUM_WORDS-1 it goes to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, result/c_out/ovf valid. start=1 in this cycle is accepted (back-to-back) and goes to RUN. Otherwise the FSM goes to IDLE.
- Latency: start sampled at edge E0. RUN occupies the NUM_WORDS cycles after E0. done is high in cycle NUM_WORDS+1 after E0. Throughput is one operation per NUM_WORDS+1 cycles.
- start while busy=1 is ignored, with no queuing. Operand inputs may change freely after the start edge.
- result words are written progressively during RUN. Consumers must use result only when done=1 or afterwards. result, c_out and ovf hold until the next DONE.
- c_out = add_cout of the final word.
- ovf = (A[W-1]==B'[W-1]) && (sum[W-1]!=A[W-1]), using the latched A and the inverted B'.
- add_a, add_b and add_cin are 0 outside RUN.
- Reset asserted mid-RUN aborts immediately to reset values, with no done pulse.
- Width: all arithmetic is modulo 2^W. Carry chains only through the carry register between words.

Optional Feature:
- Macro CLA_SEQ_SAT_EN.
- When defined, ovf=1 forces result to the signed limit: 0x7FFF…F if A[W-1]=0, else 0x800…0. The limit is applied at the RUN→DONE transition. c_out still reports the raw carry, and ovf still asserts.
- When undefined, result is the raw wrapped value.

Test Plan:
- NUM_WORDS=4, sub=0, A=0x0000_0000_0000_FFFF, B=0x1 → done 5 cycles after start edge; result=0x0000_0000_0001_0000, c_out=0, ovf=0; add_cin word1 observed =1.
- sub=0, A=B=0xFFFF_FFFF_FFFF_FFFF → result=0xFFFF_FFFF_FFFF_FFFE, c_out=1, ovf=0.
- sub=1, A=0x5, B=0x7 → result=0xFFFF_FFFF_FFFF_FFFE, c_out=0 (borrow), ovf=0; sub=1, A=B=0x1234 → result=0, c_out=1.
- sub=0, A=0x7FFF_FFFF_FFFF_FFFF, B=0x1 → ovf=1; result=0x8000_0000_0000_0000 without CLA_SEQ_SAT_EN, 0x7FFF_FFFF_FFFF_FFFF with it.
- Pulse start again while busy (cycle 2), then hold start high during the done cycle with new operands → first pulse ignored, second operation completes 5 cycles later with the correct result; busy never drops between the two operations except in the done cycle.
- Assert rst_n=0 in the third RUN cycle → all outputs 0 asynchronously, no done; after release a new start completes normally.

Source files
------------

// File: rtl/cla_word_sequencer_if.sv
// Bus bundle between the ALU control path, the word sequencer and the shared 16-bit CLA.
interface cla_word_sequencer_if #(parameter int NUM_WORDS = 4);
  localparam int W = 16 * NUM_WORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [15:0]  add_a;
  logic [15:0]  add_b;
  logic         add_cin;
  logic [15:0]  add_sum;
  logic         add_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         c_out;
  logic         ovf;

  modport master (
    output start, sub, op_a, op_b,
    input  busy, done, result, c_out, ovf
  );

  modport slave (
    input  start, sub, op_a, op_b, add_sum, add_cout,
    output add_a, add_b, add_cin, busy, done, result, c_out, ovf
  );

  modport adder (
    input  add_a, add_b, add_cin,
    output add_sum, add_cout
  );
endinterface

// File: rtl/cla_word_sequencer.sv
// Multi-word add/subtract sequencer driving one shared 16-bit CLA, LS word first.
// Optional saturation on signed overflow when CLA_SEQ_SAT_EN is defined.
module cla_word_sequencer #(
  parameter int NUM_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cla_word_sequencer_if.slave   bus
);
  localparam int W  = 16 * NUM_WORDS;
  localparam int IW = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [IW-1:0]  r_idx;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_carry;
  logic [W-1:0]   r_result;
  logic           r_c_out;
  logic           r_ovf;
  logic           w_accept;
  logic           w_run;
  logic           w_last;
  logic           w_ovf;
  logic [IW+3:0]  w_base;

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_idx == IW'(NUM_WORDS - 1));
  assign w_base = {r_idx, 4'd0};
  // Signs come from the latched A and the already-inverted B; the MSB of the last word is the result sign.
  assign w_ovf  = (r_a[W-1] == r_b[W-1]) && (bus.add_sum[15] != r_a[W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next   = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end else begin
          w_next   = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_c_out  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_a     <= bus.op_a;
      r_b     <= bus.op_b ^ {W{bus.sub}};
      r_carry <= bus.sub;
    end else if (w_run) begin
      r_result[w_base +: 16] <= bus.add_sum;
      r_carry                <= bus.add_cout;
      r_idx                  <= r_idx + IW'(1);
      if (w_last) begin
        r_c_out <= bus.add_cout;
        r_ovf   <= w_ovf;
`ifdef CLA_SEQ_SAT_EN
        if (w_ovf) begin
          r_result <= {r_a[W-1], {(W-1){~r_a[W-1]}}};
        end
`endif
      end
    end
  end

  assign bus.busy    = w_run;
  assign bus.done    = (r_state == S_DONE);
  assign bus.add_a   = w_run ? r_a[w_base +: 16] : 16'h0000;
  assign bus.add_b   = w_run ? r_b[w_base +: 16] : 16'h0000;
  assign bus.add_cin = w_run ? r_carry : 1'b0;
  assign bus.result  = r_result;
  assign bus.c_out   = r_c_out;
  assign bus.ovf     = r_ovf;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Bench for cla_word_sequencer: whole-width arithmetic model plus directed vectors with literal expectations.
module tb_cla_word_sequencer;
  localparam int NW = 4;
  localparam int W  = 16 * NW;
  typedef logic [W:0]   val_t;
  typedef logic [W+1:0] res_t;

`ifdef CLA_SEQ_SAT_EN
  localparam logic [W-1:0] T4_RES = 64'h7FFF_FFFF_FFFF_FFFF;
`else
  localparam logic [W-1:0] T4_RES = 64'h8000_0000_0000_0000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  cla_word_sequencer_if #(.NUM_WORDS(NW)) bus ();

  // Shared CLA stand-in: plain 17-bit addition
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};

  cla_word_sequencer #(.NUM_WORDS(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input val_t act, input val_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {ovf, carry, result} for the whole operation
  function automatic res_t calc(input logic [W-1:0] a, input logic [W-1:0] bp, input logic s);
    val_t         full;
    logic [W-1:0] res;
    logic         o;
    full = {1'b0, a} + {1'b0, bp} + val_t'(s);
    res  = full[W-1:0];
    o    = (a[W-1] == bp[W-1]) && (res[W-1] != a[W-1]);
`ifdef CLA_SEQ_SAT_EN
    if (o) res = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {o, full[W], res};
  endfunction

  function automatic logic [15:0] word_of(input logic [W-1:0] v, input int k);
    return v[16*k +: 16];
  endfunction

  // Carry entering bit 16k of A + B' + sub
  function automatic logic cin_into(input logic [W-1:0] a, input logic [W-1:0] bp, input logic s, input int k);
    val_t mask;
    val_t part;
    mask = (val_t'(1) << (16 * k)) - val_t'(1);
    part = (val_t'(a) & mask) + (val_t'(bp) & mask) + val_t'(s);
    return part[16 * k];
  endfunction

  int           m_phase;
  logic [W-1:0] m_a;
  logic [W-1:0] m_bp;
  logic         m_sub;
  res_t         m_pend;
  res_t         m_exp;

  // Model: phase 0 idle, 1..NW running word phase-1, NW+1 done
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_a     <= '0;
      m_bp    <= '0;
      m_sub   <= 1'b0;
      m_pend  <= '0;
      m_exp   <= '0;
    end else if (m_phase == 0 || m_phase == NW + 1) begin
      if (bus.start) begin
        m_phase <= 1;
        m_a     <= bus.op_a;
        m_bp    <= bus.sub ? ~bus.op_b : bus.op_b;
        m_sub   <= bus.sub;
        m_pend  <= calc(bus.op_a, bus.sub ? ~bus.op_b : bus.op_b, bus.sub);
      end else begin
        m_phase <= 0;
      end
    end else if (m_phase == NW) begin
      m_phase <= NW + 1;
      m_exp   <= m_pend;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (m_phase >= 1 && m_phase <= NW) begin
      check("busy_run", val_t'(bus.busy), val_t'(1'b1));
      check("done_run", val_t'(bus.done), val_t'(1'b0));
      check("add_a", val_t'(bus.add_a), val_t'(word_of(m_a, m_phase - 1)));
      check("add_b", val_t'(bus.add_b), val_t'(word_of(m_bp, m_phase - 1)));
      check("add_cin", val_t'(bus.add_cin), val_t'(cin_into(m_a, m_bp, m_sub, m_phase - 1)));
    end else begin
      check("busy_idle", val_t'(bus.busy), val_t'(1'b0));
      check("done", val_t'(bus.done), val_t'(m_phase == NW + 1));
      check("add_a_idle", val_t'(bus.add_a), val_t'(0));
      check("add_b_idle", val_t'(bus.add_b), val_t'(0));
      check("add_cin_idle", val_t'(bus.add_cin), val_t'(0));
      check("result", val_t'(bus.result), val_t'(m_exp[W-1:0]));
    end
    check("c_out", val_t'(bus.c_out), val_t'(m_exp[W]));
    check("ovf", val_t'(bus.ovf), val_t'(m_exp[W+1]));
  end

  // Waits for done from the first negedge after the start edge; lat is the cycle count
  task automatic wait_done(inout int lat, output logic cin1);
    cin1 = 1'b0;
    while (!bus.done && lat < 20) begin
      if (lat == 2) cin1 = bus.add_cin;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] er, input logic ec, input logic eo, output logic cin1);
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.sub = s; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.sub = ~s; bus.op_a = ~a; bus.op_b = a ^ b;
    lat = 1;
    wait_done(lat, cin1);
    check({nm, "_latency"}, val_t'(lat), val_t'(NW + 1));
    check({nm, "_result"}, val_t'(bus.result), val_t'(er));
    check({nm, "_c_out"}, val_t'(bus.c_out), val_t'(ec));
    check({nm, "_ovf"}, val_t'(bus.ovf), val_t'(eo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic cin1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.op_a = '0; bus.op_b = '0;
    repeat (2) @(negedge clk);
    check("rst_result", val_t'(bus.result), val_t'(0));
    check("rst_busy", val_t'(bus.busy), val_t'(0));
    rst_n = 1'b1;

    run_op("t1", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, cin1);
    check("t1_cin_word1", val_t'(cin1), val_t'(1'b1));
    run_op("t2", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, cin1);
    run_op("t3", 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, cin1);
    run_op("t3b", 64'h1234, 64'h1234, 1'b1, 64'h0, 1'b1, 1'b0, cin1);
    run_op("t4", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, T4_RES, 1'b0, 1'b1, cin1);

    // start while busy is dropped; start held in the done cycle chains the next operation
    @(negedge clk);
    bus.start = 1'b1; bus.sub = 1'b0; bus.op_a = 64'h1; bus.op_b = 64'h2;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op_a = 64'd100; bus.op_b = 64'd100;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 3;
    wait_done(lat, cin1);
    check("b2b_first_latency", val_t'(lat), val_t'(NW + 1));
    check("b2b_first_result", val_t'(bus.result), val_t'(64'h3));
    bus.start = 1'b1; bus.sub = 1'b1; bus.op_a = 64'h0001_0000_0000_0000; bus.op_b = 64'hFFFF;
    @(negedge clk);
    check("b2b_busy_after_done", val_t'(bus.busy), val_t'(1'b1));
    bus.start = 1'b0; bus.sub = 1'b0; bus.op_a = '0; bus.op_b = '0;
    lat = 1;
    wait_done(lat, cin1);
    check("b2b_second_latency", val_t'(lat), val_t'(NW + 1));
    check("b2b_second_result", val_t'(bus.result), val_t'(64'h0000_FFFF_FFFF_0001));
    check("b2b_second_c_out", val_t'(bus.c_out), val_t'(1'b1));

    // asynchronous reset during the third RUN cycle
    @(negedge clk);
    bus.start = 1'b1; bus.sub = 1'b0; bus.op_a = 64'h1111_2222_3333_4444; bus.op_b = 64'h1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", val_t'(bus.busy), val_t'(0));
    check("rst_mid_done", val_t'(bus.done), val_t'(0));
    check("rst_mid_add_a", val_t'(bus.add_a), val_t'(0));
    check("rst_mid_result", val_t'(bus.result), val_t'(0));
    check("rst_mid_c_out", val_t'(bus.c_out), val_t'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
           64'h0001_0000_0001_0000, 1'b0, 1'b0, cin1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
